// File: rtl/complex_addsub_pipe_pkg.sv
// Shared constants and signed-limit helpers for the complex add/sub butterfly pipeline.
package complex_addsub_pipe_pkg;

    localparam int unsigned DATA_FFT_SIZE = 16;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned N_COMP        = 4;

    // Most positive two's-complement value of width w (w <= 32), zero-extended.
    function automatic logic [31:0] smax_lim(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    // Most negative two's-complement value of width w (w <= 32), as a bit pattern.
    function automatic logic [31:0] smin_lim(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

endpackage

// File: rtl/complex_addsub_pipe_cplx_scale_sat.sv
// Reduces one DATA_W+1 full-precision component to DATA_W: optional floor halving,
// otherwise overflow detection with clamp or wrap.
module cplx_scale_sat
    import complex_addsub_pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [DATA_W:0]   full_i,
    input  logic              scale_i,
    output logic [DATA_W-1:0] res_c_o,
    output logic              ovf_c_o
);

    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(smax_lim(DATA_W));
    localparam logic [DATA_W-1:0] MIN_V = DATA_W'(smin_lim(DATA_W));

    // Halving drops the LSB of the extended value, so it can never leave the range.
    always_comb begin
        res_c_o = full_i[DATA_W-1:0];
        ovf_c_o = 1'b0;
        if (scale_i) begin
            res_c_o = full_i[DATA_W:1];
        end else if (full_i[DATA_W] != full_i[DATA_W-1]) begin
            ovf_c_o = 1'b1;
            if (SATURATE) begin
                res_c_o = full_i[DATA_W] ? MIN_V : MAX_V;
            end
        end
    end

endmodule

// File: rtl/complex_addsub_pipe.sv
// Two-stage radix-2 butterfly: A+B and A-B with optional halving and saturate/wrap,
// valid/ready streaming with a single global advance enable.
module complex_addsub_pipe
    import complex_addsub_pipe_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_scale,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] a_q,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] b_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sum_i,
    output logic [DATA_W-1:0] sum_q,
    output logic [DATA_W-1:0] dif_i,
    output logic [DATA_W-1:0] dif_q,
    output logic              ovf,
    output logic              ovf_sticky,
    input  logic              ovf_clr
);

    localparam int unsigned FULL_W = DATA_W + 1;

    logic              advance_c;
    logic              accept_c;
    logic [FULL_W-1:0] full_c [N_COMP];
    logic [DATA_W-1:0] res_c  [N_COMP];
    logic [N_COMP-1:0] ovf_c;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_scale_q, s1_scale_d;
    logic [FULL_W-1:0] s1_full_q [N_COMP];
    logic [FULL_W-1:0] s1_full_d [N_COMP];

    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              sticky_q, sticky_d;
    logic [DATA_W-1:0] res_q [N_COMP];
    logic [DATA_W-1:0] res_d [N_COMP];

    assign advance_c = ~out_valid_q | out_ready;
    assign accept_c  = in_valid & advance_c;
    assign in_ready  = advance_c;

    // Component order: sum_i, sum_q, dif_i, dif_q; operands sign-extended by one bit.
    assign full_c[0] = {a_i[DATA_W-1], a_i} + {b_i[DATA_W-1], b_i};
    assign full_c[1] = {a_q[DATA_W-1], a_q} + {b_q[DATA_W-1], b_q};
    assign full_c[2] = {a_i[DATA_W-1], a_i} - {b_i[DATA_W-1], b_i};
    assign full_c[3] = {a_q[DATA_W-1], a_q} - {b_q[DATA_W-1], b_q};

    for (genvar g = 0; g < N_COMP; g++) begin : g_comp
        cplx_scale_sat #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_scale_sat (
            .full_i  (s1_full_q[g]),
            .scale_i (s1_scale_q),
            .res_c_o (res_c[g]),
            .ovf_c_o (ovf_c[g])
        );
    end

    // Next-state for both stages and the sticky flag; everything holds unless advancing.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_scale_d  = s1_scale_q;
        s1_full_d   = s1_full_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        res_d       = res_q;
        sticky_d    = sticky_q;

        if (advance_c) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            ovf_d       = s1_valid_q & (|ovf_c);
        end
        if (accept_c) begin
            s1_scale_d = in_scale;
            s1_full_d  = full_c;
        end
        if (advance_c && s1_valid_q) begin
            res_d = res_c;
        end

        if (out_valid_q && out_ready && ovf_q) begin
            sticky_d = 1'b1;
        end else if (ovf_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_scale_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            sticky_q    <= 1'b0;
            for (int k = 0; k < N_COMP; k++) begin
                s1_full_q[k] <= '0;
                res_q[k]     <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_scale_q  <= s1_scale_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
            s1_full_q   <= s1_full_d;
            res_q       <= res_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;
    assign sum_i      = res_q[0];
    assign sum_q      = res_q[1];
    assign dif_i      = res_q[2];
    assign dif_q      = res_q[3];

endmodule

// File: tb/tb_complex_addsub_pipe.sv
// Bench for complex_addsub_pipe: directed corner cases plus a randomized stream,
// with a saturating and a wrapping instance fed the same stimulus.
module tb_complex_addsub_pipe;

    localparam int unsigned W  = 16;
    localparam int          NS = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_scale = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
    logic [W-1:0]  a_i = '0, a_q = '0, b_i = '0, b_q = '0;

    logic          in_ready1, out_valid1, ovf1, sticky1;
    logic          in_ready0, out_valid0, ovf0, sticky0;
    logic [W-1:0]  si1, sq1, di1, dq1, si0, sq0, di0, dq0;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit model_sticky = 1'b0;

    typedef struct packed {
        logic [W-1:0] si1, sq1, di1, dq1, si0, sq0, di0, dq0;
        logic         ovf;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    complex_addsub_pipe #(.DATA_W(W), .SATURATE(1'b1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_scale(in_scale),
        .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .out_valid(out_valid1), .out_ready(out_ready),
        .sum_i(si1), .sum_q(sq1), .dif_i(di1), .dif_q(dq1), .ovf(ovf1), .ovf_sticky(sticky1),
        .ovf_clr(ovf_clr)
    );

    complex_addsub_pipe #(.DATA_W(W), .SATURATE(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_scale(in_scale),
        .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .out_valid(out_valid0), .out_ready(out_ready),
        .sum_i(si0), .sum_q(sq0), .dif_i(di0), .dif_q(dq0), .ovf(ovf0), .ovf_sticky(sticky0),
        .ovf_clr(ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference for one component: {ovf, result}, from integer arithmetic.
    function automatic logic [16:0] ref_comp(input int full, input bit sc, input bit sat);
        int r;
        bit o;
        o = 1'b0;
        if (sc) begin
            r = full >>> 1;
        end else if (full > 32767) begin
            o = 1'b1;
            r = sat ? 32767 : full - 65536;
        end else if (full < -32768) begin
            o = 1'b1;
            r = sat ? -32768 : full + 65536;
        end else begin
            r = full;
        end
        return {o, r[15:0]};
    endfunction

    function automatic exp_t ref_model(input logic [W-1:0] ai, aq, bi, bq, input bit sc);
        exp_t e;
        int fa_i, fa_q, fb_i, fb_q;
        logic [16:0] r [8];
        fa_i = int'($signed(ai));
        fa_q = int'($signed(aq));
        fb_i = int'($signed(bi));
        fb_q = int'($signed(bq));
        r[0] = ref_comp(fa_i + fb_i, sc, 1'b1);
        r[1] = ref_comp(fa_q + fb_q, sc, 1'b1);
        r[2] = ref_comp(fa_i - fb_i, sc, 1'b1);
        r[3] = ref_comp(fa_q - fb_q, sc, 1'b1);
        r[4] = ref_comp(fa_i + fb_i, sc, 1'b0);
        r[5] = ref_comp(fa_q + fb_q, sc, 1'b0);
        r[6] = ref_comp(fa_i - fb_i, sc, 1'b0);
        r[7] = ref_comp(fa_q - fb_q, sc, 1'b0);
        e.si1 = r[0][15:0]; e.sq1 = r[1][15:0]; e.di1 = r[2][15:0]; e.dq1 = r[3][15:0];
        e.si0 = r[4][15:0]; e.sq0 = r[5][15:0]; e.di0 = r[6][15:0]; e.dq0 = r[7][15:0];
        e.ovf = r[0][16] | r[1][16] | r[2][16] | r[3][16];
        return e;
    endfunction

    // Scoreboard: the head entry must be presented (and held while stalled) until taken.
    always @(negedge clk) begin
        exp_t e;
        bit   hs_ovf;
        if (rst_n && mon_en) begin
            hs_ovf = 1'b0;
            check("sticky_sat", 32'(sticky1), 32'(model_sticky));
            check("sticky_wrap", 32'(sticky0), 32'(model_sticky));
            check("valid_match", 32'(out_valid0), 32'(out_valid1));
            if (out_valid1) begin
                check("out_has_exp", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("s_sum_i", 32'(si1), 32'(e.si1));
                    check("s_sum_q", 32'(sq1), 32'(e.sq1));
                    check("s_dif_i", 32'(di1), 32'(e.di1));
                    check("s_dif_q", 32'(dq1), 32'(e.dq1));
                    check("w_sum_i", 32'(si0), 32'(e.si0));
                    check("w_sum_q", 32'(sq0), 32'(e.sq0));
                    check("w_dif_i", 32'(di0), 32'(e.di0));
                    check("w_dif_q", 32'(dq0), 32'(e.dq0));
                    check("s_ovf", 32'(ovf1), 32'(e.ovf));
                    check("w_ovf", 32'(ovf0), 32'(e.ovf));
                    if (out_ready) begin
                        hs_ovf = e.ovf;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready1) begin
                exp_q.push_back(ref_model(a_i, a_q, b_i, b_q, in_scale));
            end
            if (hs_ovf) model_sticky = 1'b1;
            else if (ovf_clr) model_sticky = 1'b0;
        end
    end

    // One directed sample with out_ready high; returns with outputs valid at a negedge.
    task automatic send(input logic [W-1:0] ai, aq, bi, bq, input logic sc);
        @(posedge clk); #1;
        a_i = ai; a_q = aq; b_i = bi; b_q = bq; in_scale = sc;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("send_ready", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_stage1", 32'(out_valid1), 32'd0);
        @(negedge clk);
        check("lat_stage2", 32'(out_valid1), 32'd1);
    endtask

    initial begin
        int  sent;
        int  cyc;
        bit  acc;

        #12;
        check("rst_valid", 32'(out_valid1), 32'd0);
        check("rst_ovf", 32'(ovf1), 32'd0);
        check("rst_sticky", 32'(sticky1), 32'd0);
        check("rst_sum_i", 32'(si1), 32'd0);
        check("rst_dif_q", 32'(dq1), 32'd0);
        check("rst_ready", 32'(in_ready1), 32'd1);
        rst_n = 1'b1;

        send(16'h1000, 16'h0010, 16'h0100, 16'hFFF0, 1'b0);
        check("t1_sum_i", 32'(si1), 32'h1100);
        check("t1_sum_q", 32'(sq1), 32'h0000);
        check("t1_dif_i", 32'(di1), 32'h0F00);
        check("t1_dif_q", 32'(dq1), 32'h0020);
        check("t1_ovf", 32'(ovf1), 32'd0);

        send(16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        check("pos_sat_sum_i", 32'(si1), 32'h7FFF);
        check("pos_wrap_sum_i", 32'(si0), 32'h8000);
        check("pos_sat_dif_i", 32'(di1), 32'h7FFE);
        check("pos_sat_ovf", 32'(ovf1), 32'd1);
        check("pos_wrap_ovf", 32'(ovf0), 32'd1);
        @(negedge clk);
        check("pos_sticky", 32'(sticky1), 32'd1);

        send(16'h8000, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        check("neg_sat_dif_i", 32'(di1), 32'h8000);
        check("neg_wrap_dif_i", 32'(di0), 32'h7FFF);
        check("neg_ovf", 32'(ovf1), 32'd1);
        @(negedge clk);
        check("neg_sticky", 32'(sticky1), 32'd1);

        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        @(negedge clk);
        check("clr_sticky", 32'(sticky1), 32'd0);

        // Clear held through an accepted overflow sample: the set must win.
        ovf_clr = 1'b1;
        send(16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        check("setwin_pre", 32'(sticky1), 32'd0);
        @(negedge clk);
        check("setwin_sticky", 32'(sticky1), 32'd1);
        ovf_clr = 1'b0;

        send(16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 1'b1);
        check("sc_sum_i", 32'(si1), 32'h4000);
        check("sc_dif_i", 32'(di1), 32'h3FFF);
        check("sc_ovf", 32'(ovf1), 32'd0);
        send(16'hFFFF, 16'h8000, 16'h0000, 16'h8000, 1'b1);
        check("sc_floor_sum_i", 32'(si1), 32'hFFFF);
        check("sc_minmin_sum_q", 32'(sq1), 32'h8000);
        check("sc_floor_ovf", 32'(ovf0), 32'd0);

        // Random stream against the scoreboard, out_ready and ovf_clr toggling.
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        mon_en = 1'b1;
        sent = 0;
        cyc  = 0;
        while ((sent < NS || in_valid || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            acc = in_valid && in_ready1;
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            if (!in_valid || acc) begin
                if (sent < NS && $urandom_range(0, 3) != 0) begin
                    a_i = W'($urandom); a_q = W'($urandom);
                    b_i = W'($urandom); b_q = W'($urandom);
                    if ($urandom_range(0, 5) == 0) a_i = 16'h7FFF;
                    if ($urandom_range(0, 5) == 0) b_q = 16'h8000;
                    in_scale = ($urandom_range(0, 3) == 0);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("stream_sent", 32'(sent), 32'(NS));
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        ovf_clr = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;

        // Fill both stages under backpressure, then reset mid-cycle.
        @(posedge clk); #1;
        out_ready = 1'b0;
        a_i = 16'h1234; a_q = 16'h0001; b_i = 16'h0002; b_q = 16'h0003; in_scale = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk); #3;
        check("pre_rst_valid", 32'(out_valid1), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid1), 32'd0);
        check("midrst_sum_i", 32'(si1), 32'd0);
        check("midrst_wrap_sum_i", 32'(si0), 32'd0);
        check("midrst_ovf", 32'(ovf1), 32'd0);
        check("midrst_sticky", 32'(sticky1), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_partial", 32'(out_valid1 | out_valid0), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
